// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and sizing helpers for the digit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Count must reach NDIG, so it needs $clog2(NDIG+1) bits, never fewer than one.
    function automatic int calc_cnt_w(input int ndig);
        int w;
        w = $clog2(ndig + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ripple_adder_slice.sv
// rtl/ripple_adder_slice.sv - combinational DIGIT-bit ripple adder exposing carry-out and carry into its MSB
module ripple_adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [DIGIT:0] ch;

    assign ch[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ ch[i];
        assign ch[i+1]  = (a[i] & b[i]) | (ch[i] & (a[i] ^ b[i]));
    end

    assign cout    = ch[DIGIT];
    assign msb_cin = ch[DIGIT-1];

endmodule

// File: rtl/serial_adder_nbit.sv
// rtl/serial_adder_nbit.sv - multi-cycle digit-serial adder with start/done handshake, carry-out and signed overflow
module serial_adder_nbit
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = calc_cnt_w(NDIG);

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opa, opb, acc, acc_nx;
    logic             carry;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout, msb_cin, last;

    ripple_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a       (opa[DIGIT-1:0]),
        .b       (opb[DIGIT-1:0]),
        .cin     (carry),
        .sum     (slice_sum),
        .cout    (slice_cout),
        .msb_cin (msb_cin)
    );

    // New digit enters at the top; after NDIG shifts the first digit sits at bit 0.
    assign acc_nx = WIDTH'({slice_sum, acc} >> DIGIT);
    assign last   = (count == CW'(NDIG - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = start ? S_RUN : S_IDLE;
            S_RUN:          state_nx = last ? S_DONE : S_RUN;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        count <= '0;
                        acc   <= '0;
                    end
                end
                S_RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    acc   <= acc_nx;
                    carry <= slice_cout;
                    count <= count + CW'(1);
                    if (last) begin
                        sum      <= acc_nx;
                        cout     <= slice_cout;
                        overflow <= msb_cin ^ slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
